// File: rtl/inv_sub_byte_engine.sv
// Multi-cycle AES InvSubBytes engine: substitutes BYTES_PER_CYCLE state bytes per clock
// behind a valid/ready handshake on both the input and output side.

// 256-entry FIPS-197 inverse S-box; upper nibble selects the row, lower nibble the column.
module inv_sbox (
  input  logic [7:0] dataIn,
  output logic [7:0] dataOut_c
);
  localparam logic [7:0] INV_SBOX [16][16] = '{
    '{8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb},
    '{8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb},
    '{8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e},
    '{8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25},
    '{8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92},
    '{8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84},
    '{8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06},
    '{8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b},
    '{8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73},
    '{8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e},
    '{8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b},
    '{8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4},
    '{8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f},
    '{8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef},
    '{8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61},
    '{8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d}
  };

  assign dataOut_c = INV_SBOX[dataIn[7:4]][dataIn[3:0]];
endmodule

module inv_sub_byte_engine #(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in_state,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_state,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int unsigned STATE_W  = 128;
  localparam int unsigned GRP_W    = 8 * BYTES_PER_CYCLE;
  localparam int unsigned NUM_GRP  = 16 / BYTES_PER_CYCLE;
  localparam int unsigned CNT_W    = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int unsigned SH_W     = 8;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GRP - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT               state, stateNext;
  logic [CNT_W-1:0]    cnt, cntNext;
  logic [STATE_W-1:0]  workReg, workNext;
  logic                loadOut;
  logic [SH_W-1:0]     shAmt;
  logic [GRP_W-1:0]    grpIn, grpOut;
  logic [STATE_W-1:0]  grpMask, grpBits;

  // Align group cnt to the top of the word, then build its mask and substituted bits in place.
  always_comb begin
    shAmt   = SH_W'(GRP_W) * SH_W'(cnt);
    grpIn   = GRP_W'((workReg << shAmt) >> (STATE_W - GRP_W));
    grpMask = (~({STATE_W{1'b1}} >> GRP_W)) >> shAmt;
    grpBits = (STATE_W'(grpOut) << (STATE_W - GRP_W)) >> shAmt;
  end

  for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : gSbox
    inv_sbox uSbox (
      .dataIn   (grpIn[GRP_W-1-8*b -: 8]),
      .dataOut_c(grpOut[GRP_W-1-8*b -: 8])
    );
  end

  // Next-state and datapath control.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    workNext  = workReg;
    loadOut   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          stateNext = BUSY;
          cntNext   = '0;
          workNext  = in_state;
        end
      end
      BUSY: begin
        workNext = (workReg & ~grpMask) | grpBits;
        cntNext  = CNT_W'(cnt + 1'b1);
        if (cnt == LAST_GRP) begin
          stateNext = DONE;
          loadOut   = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode, so they track state alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      workReg   <= '0;
      out_state <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      workReg   <= workNext;
      if (loadOut) out_state <= workNext;
      in_ready  <= (stateNext == IDLE);
      out_valid <= (stateNext == DONE);
    end
  end
endmodule

// File: tb/tb_inv_sub_byte_engine.sv
// Directed bench for inv_sub_byte_engine at 1, 4 and 16 bytes per cycle; the reference
// inverse S-box is derived from GF(2^8) arithmetic rather than a copied table.
module tb_inv_sub_byte_engine;
  localparam logic [127:0] ALL63 = {16{8'h63}};
  localparam logic [127:0] V029  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] E029  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V030  = 128'h00ff1663636363636363636363636363;
  localparam logic [127:0] E030  = 128'h527dff00000000000000000000000000;

  logic         clk, rst_n;
  logic [127:0] inState;
  logic         outReady;
  logic         inValid4, inReady4, outValid4;
  logic         inValid1, inReady1, outValid1;
  logic         inValid16, inReady16, outValid16;
  logic [127:0] outState4, outState1, outState16;

  int nTests = 0;
  int nFail  = 0;
  logic [7:0] refInv [256];

  inv_sub_byte_engine #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_state(inState), .in_valid(inValid4), .in_ready(inReady4),
    .out_state(outState4), .out_valid(outValid4), .out_ready(outReady));
  inv_sub_byte_engine #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_state(inState), .in_valid(inValid1), .in_ready(inReady1),
    .out_state(outState1), .out_valid(outValid1), .out_ready(outReady));
  inv_sub_byte_engine #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_state(inState), .in_valid(inValid16), .in_ready(inReady16),
    .out_state(outState16), .out_valid(outValid16), .out_ready(outReady));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic hi;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] fwdSbox(input logic [7:0] a);
    logic [7:0] inv, r, s;
    inv = 8'h00;
    if (a != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gfMul(a, 8'(y)) == 8'h01) inv = 8'(y);
    r = inv; s = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] refState(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = refInv[v[8*i +: 8]];
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the 4-byte engine; entered at a negedge with the engine idle and out_ready=1.
  task automatic runOne(input string tag, input logic [127:0] vec, input logic [127:0] exp);
    logic [127:0] prev;
    int lat;
    prev = outState4;
    inState = vec; inValid4 = 1'b1;
    @(negedge clk);
    inValid4 = 1'b0; lat = 0;
    check({tag, "_busy_hold"}, outState4, prev);
    check({tag, "_busy_rdy"}, 128'(inReady4), 128'(0));
    while (!outValid4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(4));
    check({tag, "_data"}, outState4, exp);
    @(negedge clk);
    check({tag, "_idle_rdy"}, 128'(inReady4), 128'(1));
    check({tag, "_idle_ov"}, 128'(outValid4), 128'(0));
  endtask

  initial begin
    logic [127:0] res4, res1, res16, vecs[4];
    int lat4, lat1, lat16, lat, sent, got, lastT, cyc;

    for (int a = 0; a < 256; a++) refInv[fwdSbox(8'(a))] = 8'(a);

    rst_n = 1'b0; inState = '0; outReady = 1'b0;
    inValid4 = 1'b0; inValid1 = 1'b0; inValid16 = 1'b0;

    // Reset state, held across several clock edges.
    repeat (3) @(negedge clk);
    check("rst_rdy", 128'(inReady4), 128'(1));
    check("rst_ov", 128'(outValid4), 128'(0));
    check("rst_data", outState4, '0);
    check("rst_rdy1", 128'(inReady1), 128'(1));
    check("rst_rdy16", 128'(inReady16), 128'(1));
    rst_n = 1'b1;

    // All-0x63 state with the output stalled for ten cycles.
    inState = ALL63; inValid4 = 1'b1;
    @(negedge clk);
    inValid4 = 1'b0;
    check("s63_busy_rdy", 128'(inReady4), 128'(0));
    check("s63_busy_ov", 128'(outValid4), 128'(0));
    lat = 0;
    while (!outValid4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("s63_lat", 128'(lat), 128'(4));
    check("s63_data", outState4, '0);
    for (int i = 0; i < 10; i++) begin
      inValid4 = (i == 3);
      inState  = (i == 3) ? V029 : ALL63;
      @(negedge clk);
      check("stall_ov", 128'(outValid4), 128'(1));
      check("stall_data", outState4, '0);
      check("stall_rdy", 128'(inReady4), 128'(0));
    end
    inValid4 = 1'b0; outReady = 1'b1;
    @(negedge clk);
    check("release_rdy", 128'(inReady4), 128'(1));
    check("release_ov", 128'(outValid4), 128'(0));
    check("release_hold", outState4, '0);

    // Same vector into all three widths; latency must be 16/BYTES_PER_CYCLE.
    inState = V029; inValid4 = 1'b1; inValid1 = 1'b1; inValid16 = 1'b1;
    @(negedge clk);
    inValid4 = 1'b0; inValid1 = 1'b0; inValid16 = 1'b0;
    lat4 = -1; lat1 = -1; lat16 = -1; res4 = '0; res1 = '0; res16 = '0;
    for (int c = 0; c < 30; c++) begin
      if (outValid4 && lat4 < 0) begin lat4 = c; res4 = outState4; end
      if (outValid1 && lat1 < 0) begin lat1 = c; res1 = outState1; end
      if (outValid16 && lat16 < 0) begin lat16 = c; res16 = outState16; end
      @(negedge clk);
    end
    check("bpc4_lat", 128'(lat4), 128'(4));
    check("bpc4_data", res4, E029);
    check("bpc1_lat", 128'(lat1), 128'(16));
    check("bpc1_data", res1, E029);
    check("bpc16_lat", 128'(lat16), 128'(1));
    check("bpc16_data", res16, E029);

    runOne("lead", V030, E030);

    // Back-to-back random states; in_valid stays high with junk data while busy.
    for (int i = 0; i < 4; i++) vecs[i] = {$urandom, $urandom, $urandom, $urandom};
    sent = 0; got = 0; lastT = -1; cyc = 0;
    while (got < 4 && cyc < 200) begin
      if (outValid4) begin
        check("b2b_data", outState4, refState(vecs[got]));
        if (got > 0) check("b2b_gap", 128'(cyc - lastT), 128'(6));
        lastT = cyc;
        got++;
      end
      if (sent < 4) begin
        inValid4 = 1'b1;
        if (inReady4) begin
          inState = vecs[sent];
          sent++;
        end else begin
          inState = {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        inValid4 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    inValid4 = 1'b0;
    check("b2b_count", 128'(got), 128'(4));
    @(negedge clk);

    // Reset asserted with cnt=2 in BUSY.
    inState = V029; inValid4 = 1'b1;
    @(negedge clk);
    inValid4 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ov", 128'(outValid4), 128'(0));
    check("midrst_data", outState4, '0);
    check("midrst_rdy", 128'(inReady4), 128'(1));
    @(negedge clk);
    check("midrst_hold_ov", 128'(outValid4), 128'(0));
    check("midrst_hold_rdy", 128'(inReady4), 128'(1));
    rst_n = 1'b1;
    runOne("recover", V029, E029);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/inv_sub_byte_engine.md
INV_SUB_BYTE_ENGINE -- requirements
Module: inv_sub_byte_engine

Interface
REQ-001 The module SHALL have parameter BYTES_PER_CYCLE, default 4: number of state bytes substituted per clock; legal values 1, 2, 4, 8, 16.
REQ-002 The module SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 The module SHALL have port in_state, input, 128: AES state to inverse-substitute; byte r,c at bits [127-8(4c+r) -: 8].
REQ-005 The module SHALL have port in_valid, input, 1: in_state is valid.
REQ-006 The module SHALL have port in_ready, output, 1: the engine can accept a state.
REQ-007 The module SHALL have port out_state, output, 128: InvSubBytes result, same byte mapping as in_state.
REQ-008 The module SHALL have port out_valid, output, 1: out_state holds a complete result.
REQ-009 The module SHALL have port out_ready, input, 1: downstream accepts out_state.

Function
REQ-010 The engine SHALL implement states IDLE, BUSY and DONE, with N = 16/BYTES_PER_CYCLE and a byte-group counter cnt of width max(1, log2(N)).
REQ-011 In IDLE, in_ready SHALL be 1, and out_valid SHALL be 0.
REQ-012 An input handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1; it captures in_state into an internal 128-bit working register, clears cnt to 0, and moves the engine to BUSY.
REQ-013 In BUSY, in_ready SHALL be 0 and out_valid SHALL be 0.
REQ-014 Each BUSY edge SHALL replace byte group cnt of the working register with its FIPS-197 inverse S-box values; group g covers bytes at indices 16-BYTES_PER_CYCLE(g+1) to 16-BYTES_PER_CYCLE*g-1, counted from bit 127 downward, so group 0 is [127 -: 8*BYTES_PER_CYCLE].
REQ-015 On each BUSY edge, cnt SHALL increment by 1.
REQ-016 On the BUSY edge where cnt=N-1, the engine SHALL move to DONE.
REQ-017 The inverse S-box SHALL be a full 256-entry combinational table, instantiated BYTES_PER_CYCLE times, with upper nibble as row and lower nibble as column.
REQ-018 In DONE, out_valid SHALL be 1, out_state SHALL equal the working register, and in_ready SHALL be 0.
REQ-019 The engine SHALL stay in DONE, holding out_state and out_valid stable, until an edge with out_ready=1, then move to IDLE.
REQ-020 Latency SHALL be fixed: with the input handshake on edge k, out_valid rises after edge k+N; with out_ready held at 1, the next in_ready rises after edge k+N+1.
REQ-021 in_valid SHALL be ignored in BUSY and DONE, and out_ready SHALL be ignored in IDLE and BUSY.
REQ-022 In IDLE and BUSY, out_state SHALL hold its last value and SHALL be ignored downstream while out_valid=0.
REQ-023 The working register SHALL not change in IDLE except on an input handshake, and SHALL never change in DONE.
REQ-024 The module SHALL contain no combinational path from in_valid or out_ready to in_ready or out_valid; both handshake outputs SHALL be decoded from state only.

Reset
REQ-025 While rst_n=0, regardless of clk, the engine SHALL be in IDLE, with cnt=0, working register=0, out_state=0, out_valid=0 and in_ready=1.
REQ-026 Reset asserted in BUSY or DONE SHALL discard the in-flight state with no output handshake; after release the engine SHALL accept new input on the first edge with in_valid=1.
REQ-027 Reset release SHALL take effect on the first rising clk edge after rst_n rises.

Verification
REQ-028 Scenario: in_state=all 8'h63 -> out_state=all 8'h00, with out_valid after N edges (4 for the default).
REQ-029 Scenario: in_state=128'h637c777bf26b6fc53001672bfed7ab76 -> out_state=128'h000102030405060708090a0b0c0d0e0f, for each of BYTES_PER_CYCLE=1, 4, 16 (latency 16, 4, 1).
REQ-030 Scenario: in_state=128'h00ff16..., padded with 8'h63 -> leading bytes 8'h52, 8'h7d, 8'hff, remainder 8'h00.
REQ-031 Scenario: out_ready held 0 for 10 cycles in DONE -> out_state and out_valid stable, in_ready=0, a new in_valid pulse is ignored; out_ready=1 -> IDLE on next edge.
REQ-032 Scenario: rst_n pulsed low at cnt=2 of BUSY -> out_valid=0, out_state=0 and in_ready=1 immediately, no spurious output.
REQ-033 Scenario: back-to-back inputs with out_ready=1 -> one result every N+2 cycles, in order, each matching an independent inverse S-box reference model.
